// File: rtl/mp_ram_pkg.sv
// Shared helpers for the multi-port pipelined RAM: byte-enable merge and
// an elaboration-time parameter sanity check.

`ifndef MP_RAM_CHECK_PARAMS
`define MP_RAM_CHECK_PARAMS(num_ports, data_width, rd_latency) \
  if ((((data_width) % 8) != 0) || ((data_width) > mp_ram_pkg::MaxDataWidth) || \
      ((rd_latency) < 1) || ((rd_latency) > 4) || \
      ((num_ports) < 1) || ((num_ports) > 8)) begin : g_param_check \
    $fatal(1, "mp_ram_pipe: illegal NumPorts/DataWidth/RdLatency combination"); \
  end
`endif

package mp_ram_pkg;

  // Widest word the merge helper handles; callers widen and truncate.
  localparam int MaxDataWidth = 512;
  localparam int MaxBeWidth   = MaxDataWidth / 8;

  // Overlay the enabled bytes of wdata onto old_word.
  function automatic logic [MaxDataWidth-1:0] be_merge(
    input logic [MaxDataWidth-1:0] old_word,
    input logic [MaxDataWidth-1:0] wdata,
    input logic [MaxBeWidth-1:0]   be
  );
    logic [MaxDataWidth-1:0] merged;
    merged = old_word;
    for (int b = 0; b < MaxBeWidth; b++) begin
      if (be[b]) begin
        merged[b*8 +: 8] = wdata[b*8 +: 8];
      end
    end
    return merged;
  endfunction

endpackage

// File: rtl/mp_ram_rd_pipe.sv
// Per-port read-response delay line: RdLatency stages of {valid, data}.
// Data stages only load when a valid word enters them, so the last stage
// (and therefore rdata) holds its value between responses.

module mp_ram_rd_pipe #(
  parameter int DataWidth = 64,
  parameter int RdLatency = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 in_valid,
  input  logic [DataWidth-1:0] in_data,
  output logic                 out_valid,
  output logic [DataWidth-1:0] out_data
);

  logic [RdLatency-1:0]                valid_reg;
  logic [RdLatency-1:0][DataWidth-1:0] data_reg;

  // Shift valid every cycle; advance data only alongside a valid token.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_reg <= '0;
      data_reg  <= '0;
    end else begin
      for (int i = RdLatency - 1; i > 0; i--) begin
        valid_reg[i] <= valid_reg[i-1];
        if (valid_reg[i-1]) begin
          data_reg[i] <= data_reg[i-1];
        end
      end
      valid_reg[0] <= in_valid;
      if (in_valid) begin
        data_reg[0] <= in_data;
      end
    end
  end

  assign out_valid = valid_reg[RdLatency-1];
  assign out_data  = data_reg[RdLatency-1];

endmodule

// File: rtl/mp_ram_pipe.sv
// N-port byte-enabled RAM with req/gnt/rvalid handshake, per-byte
// lowest-port-wins write resolution, selectable read-during-write
// behaviour and a fixed-latency read response pipeline per port.

module mp_ram_pipe
  import mp_ram_pkg::*;
#(
  parameter int NumPorts   = 2,
  parameter int AddrWidth  = 10,
  parameter int DataWidth  = 64,
  parameter int RdLatency  = 1,
  parameter int WriteFirst = 0
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic [NumPorts-1:0]                  req_i,
  input  logic [NumPorts-1:0]                  we_i,
  input  logic [NumPorts-1:0][AddrWidth-1:0]   addr_i,
  input  logic [NumPorts-1:0][DataWidth-1:0]   wdata_i,
  input  logic [NumPorts-1:0][DataWidth/8-1:0] be_i,
  output logic [NumPorts-1:0]                  gnt_o,
  output logic [NumPorts-1:0]                  rvalid_o,
  output logic [NumPorts-1:0][DataWidth-1:0]   rdata_o
);

  localparam int BeWidth = DataWidth / 8;
  localparam int Depth   = 2 ** AddrWidth;

  `MP_RAM_CHECK_PARAMS(NumPorts, DataWidth, RdLatency)

  logic [DataWidth-1:0] mem [Depth];

  logic [NumPorts-1:0] gnt_reg;
  logic [NumPorts-1:0] acc;
  logic [NumPorts-1:0] wr_acc;
  logic [NumPorts-1:0] rd_acc;

  // Grant comes up one edge after reset release and never drops again.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      gnt_reg <= '0;
    end else begin
      gnt_reg <= '1;
    end
  end

  assign gnt_o  = gnt_reg;
  assign acc    = req_i & gnt_reg;
  assign wr_acc = acc & we_i;
  assign rd_acc = acc & ~we_i;

  // Byte-lane writes, highest port first so the lowest enabled port is the
  // last assignment to any shared byte and wins it; disjoint bytes merge.
  always_ff @(posedge clk_i) begin
    if (rst_ni) begin
      for (int p = NumPorts - 1; p >= 0; p--) begin
        if (wr_acc[p]) begin
          for (int b = 0; b < BeWidth; b++) begin
            if (be_i[p][b]) begin
              mem[addr_i[p]][b*8 +: 8] <= wdata_i[p][b*8 +: 8];
            end
          end
        end
      end
    end
  end

  for (genvar gi = 0; gi < NumPorts; gi++) begin : g_port
    logic [DataWidth-1:0] old_word;
    logic [DataWidth-1:0] rd_word;

    assign old_word = mem[addr_i[gi]];

    // Read word at acceptance: old contents, or overlaid with this cycle's
    // resolved writes to the same address (lowest port applied last).
    always_comb begin
      rd_word = old_word;
      if (WriteFirst != 0) begin
        for (int q = NumPorts - 1; q >= 0; q--) begin
          if (wr_acc[q] && (addr_i[q] == addr_i[gi])) begin
            rd_word = DataWidth'(be_merge(MaxDataWidth'(rd_word),
                                          MaxDataWidth'(wdata_i[q]),
                                          MaxBeWidth'(be_i[q])));
          end
        end
      end
    end

    mp_ram_rd_pipe #(
      .DataWidth(DataWidth),
      .RdLatency(RdLatency)
    ) u_rd_pipe (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .in_valid (rd_acc[gi]),
      .in_data  (rd_word),
      .out_valid(rvalid_o[gi]),
      .out_data (rdata_o[gi])
    );

    // A response only ever follows an accepted read RdLatency cycles back.
    a_rvalid_origin: assert property (
      @(posedge clk_i) disable iff (!rst_ni)
      rvalid_o[gi] |-> $past(rd_acc[gi], RdLatency)
    );
  end

endmodule

// File: tb/tb_mp_ram_pipe.sv
// Directed bench for mp_ram_pipe. Two instances share all stimulus:
// u_dut_rf (RdLatency 3, old-data read-during-write) and
// u_dut_wf (RdLatency 1, merged-data read-during-write).

module tb_mp_ram_pipe;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  logic [1:0]        req   = '0;
  logic [1:0]        we    = '0;
  logic [1:0][9:0]   addr  = '0;
  logic [1:0][63:0]  wdata = '0;
  logic [1:0][7:0]   be    = '0;

  logic [1:0]        gnt_a, gnt_b;
  logic [1:0]        rvalid_a, rvalid_b;
  logic [1:0][63:0]  rdata_a, rdata_b;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  always #5 clk = ~clk;

  mp_ram_pipe #(
    .NumPorts(2), .AddrWidth(10), .DataWidth(64), .RdLatency(3), .WriteFirst(0)
  ) u_dut_rf (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .we_i(we), .addr_i(addr),
    .wdata_i(wdata), .be_i(be), .gnt_o(gnt_a), .rvalid_o(rvalid_a), .rdata_o(rdata_a)
  );

  mp_ram_pipe #(
    .NumPorts(2), .AddrWidth(10), .DataWidth(64), .RdLatency(1), .WriteFirst(1)
  ) u_dut_wf (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .we_i(we), .addr_i(addr),
    .wdata_i(wdata), .be_i(be), .gnt_o(gnt_b), .rvalid_o(rvalid_b), .rdata_o(rdata_b)
  );

  function automatic logic [63:0] pat(input int i);
    return 64'hC0DE_5A5A_0000_0000 + 64'(i) * 64'h0000_0000_0101_0101;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_word(input int p, input logic [9:0] a,
                            input logic [63:0] d, input logic [7:0] b);
    req[p] = 1'b1; we[p] = 1'b1; addr[p] = a; wdata[p] = d; be[p] = b;
    tick();
    req = '0; we = '0; be = '0;
  endtask

  // Caller has set up stimulus; this ticks, drops all requests after the
  // first edge, and captures the first response of port p on each instance.
  task automatic collect(input int p,
                         output logic sa, output int la, output logic [63:0] da,
                         output logic sb, output int lb, output logic [63:0] db);
    sa = 1'b0; la = 0; da = '0;
    sb = 1'b0; lb = 0; db = '0;
    for (int n = 1; n <= 8; n++) begin
      tick();
      if (n == 1) begin
        req = '0; we = '0; be = '0;
      end
      if (rvalid_a[p] && !sa) begin sa = 1'b1; la = n; da = rdata_a[p]; end
      if (rvalid_b[p] && !sb) begin sb = 1'b1; lb = n; db = rdata_b[p]; end
    end
  endtask

  task automatic issue_read(input int p, input logic [9:0] a,
                            output logic sa, output int la, output logic [63:0] da,
                            output logic sb, output int lb, output logic [63:0] db);
    req[p] = 1'b1; we[p] = 1'b0; addr[p] = a;
    collect(p, sa, la, da, sb, lb, db);
  endtask

  task automatic test_reset();
    #3 rst_n = 1'b0;
    tick(); tick();
    chk_cnt++; if (gnt_a !== 2'b00) $display("FAIL rst_gnt_a: got %b want 00", gnt_a); else pass_cnt++;
    chk_cnt++; if (gnt_b !== 2'b00) $display("FAIL rst_gnt_b: got %b want 00", gnt_b); else pass_cnt++;
    chk_cnt++; if ({rvalid_a, rvalid_b} !== 4'b0) $display("FAIL rst_rvalid: got %b want 0000", {rvalid_a, rvalid_b}); else pass_cnt++;
    chk_cnt++; if (rdata_a !== '0) $display("FAIL rst_rdata_a: got %h want 0", rdata_a); else pass_cnt++;
    chk_cnt++; if (rdata_b !== '0) $display("FAIL rst_rdata_b: got %h want 0", rdata_b); else pass_cnt++;
    rst_n = 1'b1;
    #2;
    chk_cnt++; if (gnt_a !== 2'b00) $display("FAIL rel_gnt_early: got %b want 00", gnt_a); else pass_cnt++;
    #2;
    tick();
    chk_cnt++; if (gnt_a !== 2'b11) $display("FAIL rel_gnt_a: got %b want 11", gnt_a); else pass_cnt++;
    chk_cnt++; if (gnt_b !== 2'b11) $display("FAIL rel_gnt_b: got %b want 11", gnt_b); else pass_cnt++;
    $display("reset: gnt_a=%b gnt_b=%b after release", gnt_a, gnt_b);
  endtask

  task automatic test_write_read();
    logic sa, sb; int la, lb; logic [63:0] da, db;
    logic [63:0] exp_d = 64'h1122_3344_5566_7788;
    write_word(0, 10'h005, exp_d, 8'hFF);
    issue_read(1, 10'h005, sa, la, da, sb, lb, db);
    chk_cnt++; if (sa !== 1'b1) $display("FAIL wr_rd_seen_a: got %b want 1", sa); else pass_cnt++;
    chk_cnt++; if (la != 3) $display("FAIL wr_rd_lat_a: got %0d want 3", la); else pass_cnt++;
    chk_cnt++; if (da !== exp_d) $display("FAIL wr_rd_data_a: got %h want %h", da, exp_d); else pass_cnt++;
    chk_cnt++; if (lb != 1) $display("FAIL wr_rd_lat_b: got %0d want 1", lb); else pass_cnt++;
    chk_cnt++; if (db !== exp_d) $display("FAIL wr_rd_data_b: got %h want %h", db, exp_d); else pass_cnt++;
    chk_cnt++; if (rvalid_a[1] !== 1'b0 || rdata_a[1] !== exp_d)
      $display("FAIL rdata_hold: got v=%b d=%h want v=0 d=%h", rvalid_a[1], rdata_a[1], exp_d); else pass_cnt++;
    $display("write_read: lat_a=%0d data_a=%h lat_b=%0d data_b=%h", la, da, lb, db);
  endtask

  task automatic test_collision();
    logic sa, sb; int la, lb; logic [63:0] da, db;
    logic [63:0] exp_d = 64'h0000_BBBB_AAAA_AAAA;
    write_word(0, 10'h010, 64'h0, 8'hFF);
    req = 2'b11; we = 2'b11;
    addr[0] = 10'h010; addr[1] = 10'h010;
    wdata[0] = {8{8'hAA}}; wdata[1] = {8{8'hBB}};
    be[0] = 8'h0F; be[1] = 8'h3C;
    tick();
    req = '0; we = '0; be = '0;
    issue_read(0, 10'h010, sa, la, da, sb, lb, db);
    chk_cnt++; if (da !== exp_d) $display("FAIL collision_a: got %h want %h", da, exp_d); else pass_cnt++;
    chk_cnt++; if (db !== exp_d) $display("FAIL collision_b: got %h want %h", db, exp_d); else pass_cnt++;
    $display("collision: data_a=%h data_b=%h", da, db);
  endtask

  task automatic test_rdw();
    logic sa, sb; int la, lb; logic [63:0] da, db;
    write_word(0, 10'h020, 64'h0, 8'hFF);
    req = 2'b11; we = 2'b10;
    addr[0] = 10'h020; addr[1] = 10'h020;
    wdata[1] = '1; be[1] = 8'h01;
    collect(0, sa, la, da, sb, lb, db);
    chk_cnt++; if (da !== 64'h0) $display("FAIL rdw_old_a: got %h want 0", da); else pass_cnt++;
    chk_cnt++; if (la != 3) $display("FAIL rdw_lat_a: got %0d want 3", la); else pass_cnt++;
    chk_cnt++; if (db !== 64'hFF) $display("FAIL rdw_new_b: got %h want ff", db); else pass_cnt++;
    $display("rdw: write_first0=%h write_first1=%h", da, db);
    issue_read(0, 10'h020, sa, la, da, sb, lb, db);
    chk_cnt++; if (da !== 64'hFF) $display("FAIL rdw_reread_a: got %h want ff", da); else pass_cnt++;
    chk_cnt++; if (db !== 64'hFF) $display("FAIL rdw_reread_b: got %h want ff", db); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i += 2) begin
      req = 2'b11; we = 2'b11;
      addr[0] = 10'(i); addr[1] = 10'(i + 1);
      wdata[0] = pat(i); wdata[1] = pat(i + 1);
      be = {8'hFF, 8'hFF};
      tick();
    end
    req = '0; we = '0; be = '0;
    req[0] = 1'b1; addr[0] = 10'h000;
    for (int n = 1; n <= 11; n++) begin
      logic ev_a, ev_b;
      tick();
      if (n < 8) addr[0] = 10'(n); else req[0] = 1'b0;
      ev_a = (n >= 3 && n <= 10);
      ev_b = (n >= 1 && n <= 8);
      chk_cnt++; if (rvalid_a[0] !== ev_a) $display("FAIL b2b_valid_a c%0d: got %b want %b", n, rvalid_a[0], ev_a); else pass_cnt++;
      chk_cnt++; if (rvalid_b[0] !== ev_b) $display("FAIL b2b_valid_b c%0d: got %b want %b", n, rvalid_b[0], ev_b); else pass_cnt++;
      if (ev_a) begin
        chk_cnt++; if (rdata_a[0] !== pat(n - 3)) $display("FAIL b2b_data_a c%0d: got %h want %h", n, rdata_a[0], pat(n - 3)); else pass_cnt++;
      end
      if (ev_b) begin
        chk_cnt++; if (rdata_b[0] !== pat(n - 1)) $display("FAIL b2b_data_b c%0d: got %h want %h", n, rdata_b[0], pat(n - 1)); else pass_cnt++;
      end
      $display("b2b c%0d: va=%b da=%h vb=%b db=%h", n, rvalid_a[0], rdata_a[0], rvalid_b[0], rdata_b[0]);
    end
  endtask

  task automatic test_mid_reset();
    logic sa, sb; int la, lb; logic [63:0] da, db;
    req[0] = 1'b1; we[0] = 1'b0; addr[0] = 10'h000;
    tick();
    addr[0] = 10'h001;
    tick();
    req = '0;
    req[1] = 1'b1; we[1] = 1'b1; addr[1] = 10'h002; wdata[1] = 64'hDEAD_BEEF_DEAD_BEEF; be[1] = 8'hFF;
    rst_n = 1'b0;
    #1;
    chk_cnt++; if ({gnt_a, gnt_b} !== 4'b0) $display("FAIL midrst_gnt: got %b want 0000", {gnt_a, gnt_b}); else pass_cnt++;
    chk_cnt++; if ({rvalid_a, rvalid_b} !== 4'b0) $display("FAIL midrst_rvalid: got %b want 0000", {rvalid_a, rvalid_b}); else pass_cnt++;
    chk_cnt++; if (rdata_a !== '0 || rdata_b !== '0) $display("FAIL midrst_rdata: got %h %h want 0", rdata_a, rdata_b); else pass_cnt++;
    tick();
    rst_n = 1'b1;
    req = '0; we = '0; be = '0;
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk_cnt++; if ({rvalid_a, rvalid_b} !== 4'b0) $display("FAIL midrst_drop c%0d: got %b want 0000", k, {rvalid_a, rvalid_b}); else pass_cnt++;
      if (k == 1) begin
        chk_cnt++; if ({gnt_a, gnt_b} !== 4'b1111) $display("FAIL midrst_regnt: got %b want 1111", {gnt_a, gnt_b}); else pass_cnt++;
      end
    end
    for (int i = 0; i < 3; i++) begin
      issue_read(0, 10'(i), sa, la, da, sb, lb, db);
      chk_cnt++; if (da !== pat(i)) $display("FAIL midrst_mem_a %0d: got %h want %h", i, da, pat(i)); else pass_cnt++;
      chk_cnt++; if (db !== pat(i)) $display("FAIL midrst_mem_b %0d: got %h want %h", i, db, pat(i)); else pass_cnt++;
      $display("mid_reset reread addr %0d: a=%h b=%h", i, da, db);
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_collision();
    test_rdw();
    test_back_to_back();
    test_mid_reset();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed so far", pass_cnt, chk_cnt);
    $fatal(1, "timeout");
  end

endmodule
